// File: rtl/arf_rat_pkg.sv
// Shared types and the operand lookup rule for the architectural register file / rename table.
package arf_rat_pkg;

  localparam int N_ARF        = 32;
  localparam int ARF_ID_WIDTH = 5;
  localparam int ROB_ID_WIDTH = 4;
  localparam int DATA_WIDTH   = 32;

  typedef logic [ARF_ID_WIDTH-1:0] arf_id_t;
  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [DATA_WIDTH-1:0]   reg_data_t;

  typedef struct packed {
    logic      renamed;
    rob_id_t   rob_id;
    reg_data_t data;
  } lookup_t;

  // A producer retiring this very cycle is treated as already committed.
  function automatic lookup_t rat_lookup(
    input arf_id_t   id,
    input logic      tag_v,
    input rob_id_t   tag,
    input reg_data_t data,
    input logic      retire,
    input rob_id_t   retire_rob_id,
    input arf_id_t   retire_arf_id,
    input reg_data_t retire_reg_data
  );
    lookup_t res;
    res.renamed = tag_v;
    res.rob_id  = tag;
    res.data    = data;
    if (id == '0) begin
      res = '0;
    end else if (retire && (retire_arf_id == id) && tag_v && (tag == retire_rob_id)) begin
      res.renamed = 1'b0;
      res.data    = retire_reg_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/arf_rat_if.sv
// Dispatch lookup/rename and ROB retire signals bundled between the pipeline and the ARF/RAT.
interface arf_rat_if;
  import arf_rat_pkg::*;

  arf_id_t   src1_arf_id;
  logic      src1_renamed;
  rob_id_t   src1_rob_id;
  reg_data_t src1_reg_data;
  arf_id_t   src2_arf_id;
  logic      src2_renamed;
  rob_id_t   src2_rob_id;
  reg_data_t src2_reg_data;

  logic      dispatch_fire;
  logic      dispatch_dst_valid;
  arf_id_t   dispatch_dst_arf_id;
  rob_id_t   dispatch_rob_id;

  logic      retire;
  rob_id_t   retire_rob_id;
  arf_id_t   retire_arf_id;
  reg_data_t retire_reg_data;

  logic      flush;

  modport master (
    output src1_arf_id, src2_arf_id,
    output dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
    output retire, retire_rob_id, retire_arf_id, retire_reg_data, flush,
    input  src1_renamed, src1_rob_id, src1_reg_data,
    input  src2_renamed, src2_rob_id, src2_reg_data
  );

  modport slave (
    input  src1_arf_id, src2_arf_id,
    input  dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
    input  retire, retire_rob_id, retire_arf_id, retire_reg_data, flush,
    output src1_renamed, src1_rob_id, src1_reg_data,
    output src2_renamed, src2_rob_id, src2_reg_data
  );

endinterface

// File: rtl/arf_rat_rat_entry.sv
// One rename-table slot: in-flight flag plus producer ROB id for a single architectural register.
module rat_entry
  import arf_rat_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush_i,
  input  logic    rename_i,
  input  rob_id_t rename_tag_i,
  input  logic    retire_i,
  input  rob_id_t retire_tag_i,
  output logic    tag_v_o,
  output rob_id_t tag_o
);

  logic    tag_v_q, tag_v_d;
  rob_id_t tag_q, tag_d;

  // Retire clears only its own mapping; flush beats everything, rename beats retire.
  always_comb begin
    tag_v_d = tag_v_q;
    tag_d   = tag_q;
    if (retire_i && tag_v_q && (tag_q == retire_tag_i)) begin
      tag_v_d = 1'b0;
    end
    if (flush_i) begin
      tag_v_d = 1'b0;
    end else if (rename_i) begin
      tag_v_d = 1'b1;
      tag_d   = rename_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      tag_v_q <= tag_v_d;
      tag_q   <= tag_d;
    end
  end

  assign tag_v_o = tag_v_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/arf_rat.sv
// Architectural register file with alias table: commits retired values and resolves dispatch operands.
module arf_rat
  import arf_rat_pkg::*;
(
  input  logic clk,
  input  logic rst,
  arf_rat_if.slave bus
);

  reg_data_t data_q [1:N_ARF-1];
  logic      tag_v  [1:N_ARF-1];
  rob_id_t   tag    [1:N_ARF-1];
  logic      rename_en;

  assign rename_en = bus.dispatch_fire && bus.dispatch_dst_valid &&
                     (bus.dispatch_dst_arf_id != '0) && !bus.flush;

  for (genvar r = 1; r < N_ARF; r++) begin : g_rat
    rat_entry u_entry (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (bus.flush),
      .rename_i     (rename_en && (bus.dispatch_dst_arf_id == arf_id_t'(r))),
      .rename_tag_i (bus.dispatch_rob_id),
      .retire_i     (bus.retire && (bus.retire_arf_id == arf_id_t'(r))),
      .retire_tag_i (bus.retire_rob_id),
      .tag_v_o      (tag_v[r]),
      .tag_o        (tag[r])
    );
  end

  // Retired data is written regardless of whether the tag still matches or a flush is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < N_ARF; i++) begin
        data_q[i] <= '0;
      end
    end else if (bus.retire && (bus.retire_arf_id != '0)) begin
      data_q[bus.retire_arf_id] <= bus.retire_reg_data;
    end
  end

  logic      s1TagV, s2TagV;
  rob_id_t   s1Tag, s2Tag;
  reg_data_t s1Data, s2Data;
  lookup_t   s1Res, s2Res;

  always_comb begin
    s1TagV = 1'b0;
    s1Tag  = '0;
    s1Data = '0;
    s2TagV = 1'b0;
    s2Tag  = '0;
    s2Data = '0;
    if (bus.src1_arf_id != '0) begin
      s1TagV = tag_v[bus.src1_arf_id];
      s1Tag  = tag[bus.src1_arf_id];
      s1Data = data_q[bus.src1_arf_id];
    end
    if (bus.src2_arf_id != '0) begin
      s2TagV = tag_v[bus.src2_arf_id];
      s2Tag  = tag[bus.src2_arf_id];
      s2Data = data_q[bus.src2_arf_id];
    end
    s1Res = rat_lookup(bus.src1_arf_id, s1TagV, s1Tag, s1Data, bus.retire,
                       bus.retire_rob_id, bus.retire_arf_id, bus.retire_reg_data);
    s2Res = rat_lookup(bus.src2_arf_id, s2TagV, s2Tag, s2Data, bus.retire,
                       bus.retire_rob_id, bus.retire_arf_id, bus.retire_reg_data);
  end

  assign bus.src1_renamed  = s1Res.renamed;
  assign bus.src1_rob_id   = s1Res.rob_id;
  assign bus.src1_reg_data = s1Res.data;
  assign bus.src2_renamed  = s2Res.renamed;
  assign bus.src2_rob_id   = s2Res.rob_id;
  assign bus.src2_reg_data = s2Res.data;

endmodule

// File: tb/tb_arf_rat.sv
// Directed scenario bench for arf_rat: rename, retire bypass, stale retire, flush and x0 handling.
module tb_arf_rat;
  import arf_rat_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  arf_rat_if bus ();

  arf_rat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.dispatch_fire       = 1'b0;
    bus.dispatch_dst_valid  = 1'b0;
    bus.dispatch_dst_arf_id = '0;
    bus.dispatch_rob_id     = '0;
    bus.retire              = 1'b0;
    bus.retire_rob_id       = '0;
    bus.retire_arf_id       = '0;
    bus.retire_reg_data     = '0;
    bus.flush               = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input arf_id_t dst, input rob_id_t rob);
    bus.dispatch_fire       = 1'b1;
    bus.dispatch_dst_valid  = 1'b1;
    bus.dispatch_dst_arf_id = dst;
    bus.dispatch_rob_id     = rob;
  endtask

  task automatic do_retire(input rob_id_t rob, input arf_id_t dst, input reg_data_t d);
    bus.retire          = 1'b1;
    bus.retire_rob_id   = rob;
    bus.retire_arf_id   = dst;
    bus.retire_reg_data = d;
  endtask

  task automatic test_reset();
    idle();
    bus.src1_arf_id = 5'd5;
    bus.src2_arf_id = 5'd0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.src1_renamed !== 1'b0) begin failures++; $display("FAIL reset_renamed got=%0d want=0", bus.src1_renamed); end
    checks++; if (bus.src1_rob_id !== 4'd0) begin failures++; $display("FAIL reset_rob_id got=%0d want=0", bus.src1_rob_id); end
    checks++; if (bus.src1_reg_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h want=0", bus.src1_reg_data); end
  endtask

  task automatic test_rename_retire();
    dispatch(5'd5, 4'd3);
    step();
    idle();
    bus.src1_arf_id = 5'd5;
    #1;
    checks++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd3) begin failures++; $display("FAIL rename_x5 got=%0d/%0d want=1/3", bus.src1_renamed, bus.src1_rob_id); end
    do_retire(4'd3, 5'd5, 32'hDEAD);
    #1;
    checks++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'hDEAD) begin failures++; $display("FAIL retire_bypass got=%0d/%h want=0/dead", bus.src1_renamed, bus.src1_reg_data); end
    step();
    idle();
    #1;
    checks++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'hDEAD) begin failures++; $display("FAIL retire_commit got=%0d/%h want=0/dead", bus.src1_renamed, bus.src1_reg_data); end
  endtask

  task automatic test_stale_retire();
    dispatch(5'd7, 4'd2);
    step();
    dispatch(5'd7, 4'd6);
    step();
    idle();
    bus.src1_arf_id = 5'd7;
    do_retire(4'd2, 5'd7, 32'h11);
    #1;
    checks++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd6) begin failures++; $display("FAIL stale_same_cycle got=%0d/%0d want=1/6", bus.src1_renamed, bus.src1_rob_id); end
    step();
    idle();
    #1;
    checks++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd6) begin failures++; $display("FAIL stale_tag_kept got=%0d/%0d want=1/6", bus.src1_renamed, bus.src1_rob_id); end
    checks++; if (bus.src1_reg_data !== 32'h11) begin failures++; $display("FAIL stale_data_written got=%h want=11", bus.src1_reg_data); end
  endtask

  task automatic test_simultaneous();
    dispatch(5'd9, 4'd4);
    step();
    idle();
    bus.src2_arf_id = 5'd9;
    do_retire(4'd4, 5'd9, 32'h22);
    dispatch(5'd9, 4'd8);
    #1;
    checks++; if (bus.src2_renamed !== 1'b0 || bus.src2_reg_data !== 32'h22) begin failures++; $display("FAIL simul_lookup got=%0d/%h want=0/22", bus.src2_renamed, bus.src2_reg_data); end
    step();
    idle();
    #1;
    checks++; if (bus.src2_renamed !== 1'b1 || bus.src2_rob_id !== 4'd8 || bus.src2_reg_data !== 32'h22) begin failures++; $display("FAIL simul_rename_wins got=%0d/%0d/%h want=1/8/22", bus.src2_renamed, bus.src2_rob_id, bus.src2_reg_data); end
  endtask

  task automatic test_flush();
    dispatch(5'd1, 4'd1);
    step();
    dispatch(5'd2, 4'd2);
    step();
    dispatch(5'd3, 4'd3);
    step();
    idle();
    bus.src1_arf_id = 5'd3;
    #1;
    checks++; if (bus.src1_renamed !== 1'b1 || bus.src1_rob_id !== 4'd3) begin failures++; $display("FAIL pre_flush_x3 got=%0d/%0d want=1/3", bus.src1_renamed, bus.src1_rob_id); end
    bus.flush = 1'b1;
    dispatch(5'd4, 4'd5);
    step();
    idle();
    bus.src1_arf_id = 5'd1;
    bus.src2_arf_id = 5'd2;
    #1;
    checks++; if (bus.src1_renamed !== 1'b0) begin failures++; $display("FAIL flush_x1 got=%0d want=0", bus.src1_renamed); end
    checks++; if (bus.src2_renamed !== 1'b0) begin failures++; $display("FAIL flush_x2 got=%0d want=0", bus.src2_renamed); end
    bus.src1_arf_id = 5'd3;
    bus.src2_arf_id = 5'd4;
    #1;
    checks++; if (bus.src1_renamed !== 1'b0) begin failures++; $display("FAIL flush_x3 got=%0d want=0", bus.src1_renamed); end
    checks++; if (bus.src2_renamed !== 1'b0) begin failures++; $display("FAIL flush_drops_x4 got=%0d want=0", bus.src2_renamed); end
  endtask

  task automatic test_flush_retire();
    dispatch(5'd11, 4'd9);
    step();
    idle();
    bus.flush = 1'b1;
    do_retire(4'd9, 5'd11, 32'h33);
    step();
    idle();
    bus.src1_arf_id = 5'd11;
    #1;
    checks++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h33) begin failures++; $display("FAIL flush_retire got=%0d/%h want=0/33", bus.src1_renamed, bus.src1_reg_data); end
  endtask

  task automatic test_unmapped_retire();
    idle();
    bus.src1_arf_id = 5'd10;
    do_retire(4'd0, 5'd10, 32'hABC);
    #1;
    checks++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h0) begin failures++; $display("FAIL unmapped_no_bypass got=%0d/%h want=0/0", bus.src1_renamed, bus.src1_reg_data); end
    step();
    idle();
    #1;
    checks++; if (bus.src1_reg_data !== 32'hABC) begin failures++; $display("FAIL unmapped_commit got=%h want=abc", bus.src1_reg_data); end
  endtask

  task automatic test_x0();
    idle();
    bus.src1_arf_id = 5'd0;
    bus.src2_arf_id = 5'd0;
    dispatch(5'd0, 4'd7);
    do_retire(4'd7, 5'd0, 32'hFF);
    #1;
    checks++; if (bus.src1_renamed !== 1'b0 || bus.src1_reg_data !== 32'h0) begin failures++; $display("FAIL x0_same_cycle got=%0d/%h want=0/0", bus.src1_renamed, bus.src1_reg_data); end
    step();
    idle();
    #1;
    checks++; if (bus.src2_renamed !== 1'b0 || bus.src2_reg_data !== 32'h0) begin failures++; $display("FAIL x0_next_cycle got=%0d/%h want=0/0", bus.src2_renamed, bus.src2_reg_data); end
    bus.src1_arf_id = 5'd5;
    #1;
    checks++; if (bus.src1_reg_data !== 32'hDEAD || bus.src1_renamed !== 1'b0) begin failures++; $display("FAIL x0_no_side_effect got=%0d/%h want=0/dead", bus.src1_renamed, bus.src1_reg_data); end
  endtask

  initial begin
    rst = 1'b1;
    bus.src1_arf_id = '0;
    bus.src2_arf_id = '0;
    idle();
    test_reset();
    test_rename_retire();
    test_stale_retire();
    test_simultaneous();
    test_flush();
    test_flush_retire();
    test_unmapped_retire();
    test_x0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
